// File: rtl/edge_pkg.sv
// Shared types for the multi-channel edge detector: per-channel edge mode
// encoding and the mode gating helper.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_t;

  // Bit 0 of the mode enables rising edges and bit 1 enables falling edges.
  function automatic logic gate_edge(input edge_mode_t m, input logic re, input logic fe);
    logic [1:0] mb;
    mb = m;
    return (re & mb[0]) | (fe & mb[1]);
  endfunction

endpackage

// File: rtl/edge_detec_ch.sv
// One channel: synchroniser, debounce filter, registered edge pulses,
// mode gating, sticky flag and saturating event counter.
module edge_detec_ch
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 3,
  parameter int CNT_W       = 8,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_i,
  input  edge_mode_t       mode_i,
  input  logic             clr_i,
  output logic             re_o,
  output logic             fe_o,
  output logic             pulse_o,
  output logic             sticky_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   level_q, level_d;
  logic [DW-1:0]          deb_q, deb_d;
  logic                   re_q, re_d, fe_q, fe_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Outputs are single-cycle pulses with no handshake: re_o/fe_o are high for
  // exactly one clock per accepted level change and nothing downstream can stall them.
  always_comb begin
    level_d  = level_q;
    deb_d    = '0;
    re_d     = 1'b0;
    fe_d     = 1'b0;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    // The level flips on the DEB_CYCLES-th consecutive disagreeing sample.
    if (sync_out != level_q) begin
      if (deb_q == DW'(DEB_CYCLES - 1)) begin
        level_d = sync_out;
        re_d    = sync_out;
        fe_d    = ~sync_out;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
    pulse = gate_edge(mode_i, re_q, fe_q);
    if (pulse) begin
      sticky_d = 1'b1;
    end else if (clr_i) begin
      sticky_d = 1'b0;
    end
    if (clr_i) begin
      cnt_d = pulse ? CNT_W'(1) : '0;
    end else if (pulse && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= {SYNC_STAGES{INIT_LEVEL}};
      level_q  <= INIT_LEVEL;
      deb_q    <= '0;
      re_q     <= 1'b0;
      fe_q     <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], a_i};
      level_q  <= level_d;
      deb_q    <= deb_d;
      re_q     <= re_d;
      fe_q     <= fe_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign re_o     = re_q;
  assign fe_o     = fe_q;
  assign pulse_o  = pulse;
  assign sticky_o = sticky_q;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/edge_detec_multi.sv
// Multi-channel debounced edge detector: NUM_CH independent copies of
// edge_detec_ch sharing one clock and reset.
module edge_detec_multi
  import edge_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 3,
  parameter int CNT_W       = 8,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       a_in,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH-1:0]       RE_detected,
  output logic [NUM_CH-1:0]       FE_detected,
  output logic [NUM_CH-1:0]       edge_pulse,
  output logic [NUM_CH-1:0]       sticky,
  output logic [NUM_CH*CNT_W-1:0] edge_cnt
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_detec_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W),
      .INIT_LEVEL (INIT_LEVEL)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .a_i     (a_in[i]),
      .mode_i  (edge_mode_t'(mode[2*i +: 2])),
      .clr_i   (clr[i]),
      .re_o    (RE_detected[i]),
      .fe_o    (FE_detected[i]),
      .pulse_o (edge_pulse[i]),
      .sticky_o(sticky[i]),
      .cnt_o   (edge_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_edge_detec_multi.sv
// Directed bench for edge_detec_multi: expected pulses are queued when the
// input is driven and matched by a monitor whenever any pulse appears.
module tb_edge_detec_multi;

  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int DEB    = 3;
  localparam int CNT_W  = 2;
  localparam int W      = 21;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH-1:0]       a_in;
  logic [2*NUM_CH-1:0]     mode;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       RE_detected;
  logic [NUM_CH-1:0]       FE_detected;
  logic [NUM_CH-1:0]       edge_pulse;
  logic [NUM_CH-1:0]       sticky;
  logic [NUM_CH*CNT_W-1:0] edge_cnt;

  int          tests_run;
  int          tests_failed;
  logic [15:0] cyc;
  logic [W-1:0] exp_q[$];

  edge_detec_multi #(
    .NUM_CH     (NUM_CH),
    .SYNC_STAGES(SYNC),
    .DEB_CYCLES (DEB),
    .CNT_W      (CNT_W),
    .INIT_LEVEL (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a_in       (a_in),
    .mode       (mode),
    .clr        (clr),
    .RE_detected(RE_detected),
    .FE_detected(FE_detected),
    .edge_pulse (edge_pulse),
    .sticky     (sticky),
    .edge_cnt   (edge_cnt)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, cycle=%0d required=<20000", cyc);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called right after driving a new level; t0 is the next edge.
  task automatic expect_pulse(input int ch, input logic re, input logic fe, input logic ep);
    logic [15:0] at;
    at = cyc + 16'(SYNC + DEB);
    exp_q.push_back({at, 2'(ch), re, fe, ep});
  endtask

  function automatic int cnt_of(input int ch);
    return int'(edge_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_re"},     int'(RE_detected), 0);
    check({tag, "_fe"},     int'(FE_detected), 0);
    check({tag, "_pulse"},  int'(edge_pulse),  0);
    check({tag, "_sticky"}, int'(sticky),      0);
    check({tag, "_cnt"},    int'(edge_cnt),    0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (RE_detected[ch] || FE_detected[ch]) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        got = {cyc, 2'(ch), RE_detected[ch], FE_detected[ch], edge_pulse[ch]};
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_pulse: got cyc=%0d ch=%0d re=%b fe=%b ep=%b expected none",
                   cyc, ch, RE_detected[ch], FE_detected[ch], edge_pulse[ch]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            tests_failed++;
            $display("FAIL pulse: got cyc=%0d ch=%0d re/fe/ep=%b expected cyc=%0d ch=%0d re/fe/ep=%b",
                     got[20:5], got[4:3], got[2:0], exp[20:5], exp[4:3], exp[2:0]);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    clr   = '0;
    // ch3 BOTH, ch2 FALL, ch1 BOTH, ch0 RISE
    mode  = {2'b11, 2'b10, 2'b11, 2'b01};
    // ch2/ch3 already high while in reset
    a_in  = 4'b1100;
    tick(3);
    check_all_zero("reset");

    // Release: ch2 and ch3 see a new level from the first edge after release
    reset = 1'b1;
    expect_pulse(2, 1'b1, 1'b0, 1'b0);
    expect_pulse(3, 1'b1, 1'b0, 1'b1);
    tick(10);
    check("rel_sticky3", int'(sticky[3]), 1);
    check("rel_cnt3",    cnt_of(3), 1);
    check("rel_sticky2", int'(sticky[2]), 0);
    check("rel_cnt2",    cnt_of(2), 0);

    // ch0 rising edge with mode RISE
    a_in[0] = 1'b1;
    expect_pulse(0, 1'b1, 1'b0, 1'b1);
    tick(10);
    check("ch0_sticky", int'(sticky[0]), 1);
    check("ch0_cnt",    cnt_of(0), 1);

    // ch1 two-cycle glitch is filtered out
    a_in[1] = 1'b1;
    tick(2);
    a_in[1] = 1'b0;
    tick(10);
    check("glitch_cnt1",    cnt_of(1), 0);
    check("glitch_sticky1", int'(sticky[1]), 0);

    // ch2 mode FALL: 1 -> 0 -> 1
    a_in[2] = 1'b0;
    expect_pulse(2, 1'b0, 1'b1, 1'b1);
    tick(8);
    a_in[2] = 1'b1;
    expect_pulse(2, 1'b1, 1'b0, 1'b0);
    tick(8);
    check("ch2_cnt",    cnt_of(2), 1);
    check("ch2_sticky", int'(sticky[2]), 1);

    // ch3: clear, then five toggles saturate the 2-bit counter
    clr[3] = 1'b1;
    tick(1);
    clr[3] = 1'b0;
    check("clr_cnt3",    cnt_of(3), 0);
    check("clr_sticky3", int'(sticky[3]), 0);
    for (int k = 1; k <= 5; k++) begin
      a_in[3] = ~a_in[3];
      expect_pulse(3, a_in[3], ~a_in[3], 1'b1);
      tick(8);
      check($sformatf("sat_cnt3_%0d", k), cnt_of(3), (k > 3) ? 3 : k);
    end
    check("sat_sticky3", int'(sticky[3]), 1);

    // clr in the same cycle as a pulse: counter restarts at 1, sticky stays set
    a_in[3] = 1'b1;
    expect_pulse(3, 1'b1, 1'b0, 1'b1);
    tick(SYNC + DEB);
    check("clrpulse_pulse3", int'(edge_pulse[3]), 1);
    clr[3] = 1'b1;
    tick(1);
    clr[3] = 1'b0;
    check("clrpulse_cnt3",    cnt_of(3), 1);
    check("clrpulse_sticky3", int'(sticky[3]), 1);
    tick(4);
    check("other_cnt0", cnt_of(0), 1);

    // Reset mid-debounce on ch1 discards the pending edge
    a_in[1] = 1'b1;
    tick(3);
    reset = 1'b0;
    a_in  = '0;
    tick(2);
    check_all_zero("midreset");
    reset = 1'b1;
    tick(12);
    check_all_zero("postreset");

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
